// File: rtl/dma_write_controller_if.sv
// Handshake and configuration bundle between the DMA write controller and its
// AXI read slave, PCIe TLP engine, interrupt logic and job registers.
// No latency or flow control of its own; the master modport is the controller side.
interface dma_write_controller_if;
    logic [15:0]  pcie_dcommand;
    logic [31:0]  dma_write_host_address;
    logic [31:0]  dma_write_device_address;
    logic [31:0]  dma_write_length;
    logic         dma_write_start;
    logic         busy;

    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;

    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    logic [31:0]  dma_write_addr;
    logic [9:0]   dma_write_len;
    logic         dma_write_valid;
    logic         dma_write_done;

    logic [127:0] dma_write_data;
    logic         dma_write_data_valid;
    logic         dma_write_data_ready;

    logic         int_valid;
    logic         int_done;
    logic         axi_error;

    modport master (
        input  pcie_dcommand, dma_write_host_address, dma_write_device_address,
               dma_write_length, dma_write_start,
               arready, rdata, rresp, rlast, rvalid,
               dma_write_done, dma_write_data_ready, int_done,
        output busy, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
               rready, dma_write_addr, dma_write_len, dma_write_valid,
               dma_write_data, dma_write_data_valid, int_valid, axi_error
    );

    modport slave (
        output pcie_dcommand, dma_write_host_address, dma_write_device_address,
               dma_write_length, dma_write_start,
               arready, rdata, rresp, rlast, rvalid,
               dma_write_done, dma_write_data_ready, int_done,
        input  busy, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
               rready, dma_write_addr, dma_write_len, dma_write_valid,
               dma_write_data, dma_write_data_valid, int_valid, axi_error
    );
endinterface

// File: rtl/dma_write_controller.sv
// Generic synchronous FIFO used as the per-chunk store-and-forward buffer.
// Latency: one cycle from push to out_vld; reads are combinational from the head.
// Backpressure: in_rdy drops when full; out_vld holds until out_rdy pops the head.
module dma_fifo #(
    parameter int p_width = 128,
    parameter int p_depth = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [p_width-1:0] in_dat,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [p_width-1:0] out_dat
);
    localparam int c_aw = $clog2(p_depth);
    localparam int c_cw = $clog2(p_depth + 1);

    logic [p_width-1:0] mem [p_depth];
    logic [c_aw-1:0]    wr_ptr;
    logic [c_aw-1:0]    rd_ptr;
    logic [c_cw-1:0]    count;
    logic               push;
    logic               pop;

    assign in_rdy  = (count != c_cw'(p_depth));
    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    function automatic logic [c_aw-1:0] wrap_inc(input logic [c_aw-1:0] p);
        return (p == c_aw'(p_depth - 1)) ? '0 : p + c_aw'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= in_dat;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wrap_inc(wr_ptr);
            if (pop)  rd_ptr <= wrap_inc(rd_ptr);
            if (push && !pop)      count <= count + c_cw'(1);
            else if (!push && pop) count <= count - c_cw'(1);
        end
    end
endmodule

// DMA write: reads device memory over AXI4 in MPS/4KB-sized chunks and emits PCIe writes.
// Latency: per chunk, one AR handshake, `chunk` read beats, request accept, then `chunk` payload beats.
// Backpressure: arvalid/dma_write_valid/int_valid hold until accepted; payload stalls on data_ready.
module dma_write_controller #(
    parameter int p_buf_beats = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    dma_write_controller_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_FILL, S_REQ, S_STREAM, S_INT} state_t;

    state_t        state;
    logic [31:0]   host_addr;
    logic [31:0]   dev_addr;
    logic [27:0]   remaining;
    logic [5:0]    chunk;
    logic [5:0]    beat_cnt;

    logic [31:0]   start_host;
    logic [31:0]   start_dev;
    logic [27:0]   start_beats;
    logic [5:0]    start_chunk;
    logic [31:0]   next_host;
    logic [31:0]   next_dev;
    logic [27:0]   next_rem;
    logic [5:0]    next_chunk;
    logic [31:0]   chunk_bytes;

    logic          beat_in;
    logic          beat_out;
    logic          fifo_in_rdy;
    logic          fifo_out_vld;
    logic          fifo_out_rdy;
    logic          unused_in;

    // Largest chunk allowed by remaining length, MPS and the host 4 KB boundary.
    function automatic logic [5:0] calc_chunk(input logic [7:0] h_blk, input logic [27:0] r,
                                              input logic [2:0] code);
        logic [5:0] lim;
        logic [8:0] bnd;
        lim = (code == 3'd0) ? 6'd8 : (code == 3'd1) ? 6'd16 : 6'd32;
        bnd = 9'd256 - {1'b0, h_blk};
        if (bnd < {3'd0, lim}) lim = bnd[5:0];
        if (r < {22'd0, lim})  lim = r[5:0];
        return lim;
    endfunction

    assign start_host  = {bus.dma_write_host_address[31:4], 4'h0};
    assign start_dev   = {bus.dma_write_device_address[31:4], 4'h0};
    assign start_beats = bus.dma_write_length[31:4];
    assign start_chunk = calc_chunk(start_host[11:4], start_beats, bus.pcie_dcommand[7:5]);
    assign chunk_bytes = {22'd0, chunk, 4'h0};
    assign next_host   = host_addr + chunk_bytes;
    assign next_dev    = dev_addr + chunk_bytes;
    assign next_rem    = remaining - {22'd0, chunk};
    assign next_chunk  = calc_chunk(next_host[11:4], next_rem, bus.pcie_dcommand[7:5]);

    assign beat_in      = (state == S_FILL) && bus.rvalid && bus.rready;
    assign fifo_out_rdy = (state == S_STREAM) && bus.dma_write_data_ready;
    assign beat_out     = fifo_out_vld && fifo_out_rdy;
    assign bus.dma_write_data_valid = (state == S_STREAM) && fifo_out_vld;

    assign bus.arsize  = 3'b100;
    assign bus.arburst = 2'b01;
    assign bus.arcache = 4'b0011;
    assign bus.arprot  = 3'b000;

    assign unused_in = ^{bus.pcie_dcommand[15:8], bus.pcie_dcommand[4:0],
                         bus.dma_write_host_address[3:0], bus.dma_write_device_address[3:0],
                         bus.dma_write_length[3:0], bus.rlast, fifo_in_rdy};

    dma_fifo #(.p_width(128), .p_depth(p_buf_beats)) u_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .in_vld  (beat_in),
        .in_rdy  (fifo_in_rdy),
        .in_dat  (bus.rdata),
        .out_vld (fifo_out_vld),
        .out_rdy (fifo_out_rdy),
        .out_dat (bus.dma_write_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state               <= S_IDLE;
            host_addr           <= '0;
            dev_addr            <= '0;
            remaining           <= '0;
            chunk               <= '0;
            beat_cnt            <= '0;
            bus.busy            <= 1'b0;
            bus.axi_error       <= 1'b0;
            bus.arvalid         <= 1'b0;
            bus.araddr          <= '0;
            bus.arlen           <= '0;
            bus.rready          <= 1'b0;
            bus.dma_write_valid <= 1'b0;
            bus.dma_write_addr  <= '0;
            bus.dma_write_len   <= '0;
            bus.int_valid       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.dma_write_start) begin
                        host_addr     <= start_host;
                        dev_addr      <= start_dev;
                        remaining     <= start_beats;
                        bus.axi_error <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (start_beats == '0) begin
                            bus.int_valid <= 1'b1;
                            state         <= S_INT;
                        end else begin
                            chunk       <= start_chunk;
                            bus.araddr  <= start_dev;
                            bus.arlen   <= {2'b00, start_chunk - 6'd1};
                            bus.arvalid <= 1'b1;
                            state       <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (bus.arready) begin
                        bus.arvalid <= 1'b0;
                        bus.rready  <= 1'b1;
                        beat_cnt    <= '0;
                        state       <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (beat_in) begin
                        if (bus.rresp != 2'b00) bus.axi_error <= 1'b1;
                        beat_cnt <= beat_cnt + 6'd1;
                        if (beat_cnt == chunk - 6'd1) begin
                            bus.rready          <= 1'b0;
                            bus.dma_write_valid <= 1'b1;
                            bus.dma_write_addr  <= host_addr;
                            bus.dma_write_len   <= {2'b00, chunk, 2'b00};
                            state               <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.dma_write_done) begin
                        bus.dma_write_valid <= 1'b0;
                        beat_cnt            <= '0;
                        state               <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (beat_out) begin
                        beat_cnt <= beat_cnt + 6'd1;
                        if (beat_cnt == chunk - 6'd1) begin
                            host_addr <= next_host;
                            dev_addr  <= next_dev;
                            remaining <= next_rem;
                            if (next_rem == '0) begin
                                bus.int_valid <= 1'b1;
                                state         <= S_INT;
                            end else begin
                                chunk       <= next_chunk;
                                bus.araddr  <= next_dev;
                                bus.arlen   <= {2'b00, next_chunk - 6'd1};
                                bus.arvalid <= 1'b1;
                                state       <= S_AR;
                            end
                        end
                    end
                end
                S_INT: begin
                    if (bus.int_done) begin
                        bus.int_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_write_controller.sv
// Scoreboard bench for dma_write_controller: a chunking model fills expectation queues,
// and independent AXI/PCIe/interrupt monitors pop and compare as the DUT presents traffic.
module tb_dma_write_controller;
    typedef struct packed {
        logic [31:0] addr;
        logic [9:0]  len;
    } xfer_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_write_controller_if bus();

    dma_write_controller #(.p_buf_beats(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int ints_seen = 0;
    int credit = 0;
    int data_beats = 0;
    bit stall = 1'b0;
    bit inject = 1'b0;
    logic [31:0] err_addr = '0;

    xfer_t        exp_ar[$];
    xfer_t        exp_req[$];
    xfer_t        act_ar[$];
    xfer_t        act_req[$];
    xfer_t        r_bursts[$];
    logic [127:0] exp_data[$];
    bit           exp_int[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] memf(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, ~a, a + 32'h13579BDF, a[15:0], a[31:16]};
    endfunction

    function automatic bit rnd_rdy();
        return !stall || ($urandom_range(0, 3) != 0);
    endfunction

    // AXI read-address slave
    initial begin
        xfer_t a, e;
        bit have;
        bus.arready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.arready = 1'b0;
                r_bursts.delete();
            end else begin
                bus.arready = rnd_rdy();
                if (bus.arvalid && bus.arready) begin
                    a.addr = bus.araddr;
                    a.len  = {2'b00, bus.arlen};
                    act_ar.push_back(a);
                    r_bursts.push_back(a);
                    have = exp_ar.size() > 0;
                    e = '0;
                    if (have) e = exp_ar.pop_front();
                    chk("ar_present", have, 1);
                    chk("ar_addr", a.addr, e.addr);
                    chk("ar_len", a.len, e.len);
                    chk("ar_attr", {bus.arsize, bus.arburst, bus.arcache, bus.arprot},
                        {3'b100, 2'b01, 4'b0011, 3'b000});
                end
            end
        end
    end

    // AXI read-data slave: memory contents come from memf(address)
    initial begin
        int beat;
        bit pacc;
        logic [31:0] a;
        beat = 0;
        pacc = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata = '0;
        bus.rresp = 2'b00;
        bus.rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.rvalid = 1'b0;
                beat = 0;
                pacc = 1'b0;
            end else begin
                if (pacc) begin
                    beat++;
                    if (beat > int'(r_bursts[0].len)) begin
                        void'(r_bursts.pop_front());
                        beat = 0;
                    end
                end
                if (!bus.rvalid || pacc) begin
                    if (r_bursts.size() > 0 && rnd_rdy()) begin
                        a = r_bursts[0].addr + 32'(beat * 16);
                        bus.rvalid = 1'b1;
                        bus.rdata  = memf(a);
                        bus.rresp  = (inject && a == err_addr) ? 2'b10 : 2'b00;
                        bus.rlast  = (beat == int'(r_bursts[0].len));
                    end else begin
                        bus.rvalid = 1'b0;
                    end
                end
                pacc = bus.rvalid && bus.rready;
            end
        end
    end

    // PCIe request acceptor
    initial begin
        xfer_t a, e;
        bit have;
        bus.dma_write_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.dma_write_done = 1'b0;
                credit = 0;
            end else begin
                bus.dma_write_done = bus.dma_write_valid && rnd_rdy();
                if (bus.dma_write_done) begin
                    a.addr = bus.dma_write_addr;
                    a.len  = bus.dma_write_len;
                    act_req.push_back(a);
                    have = exp_req.size() > 0;
                    e = '0;
                    if (have) e = exp_req.pop_front();
                    chk("req_present", have, 1);
                    chk("req_addr", a.addr, e.addr);
                    chk("req_len", a.len, e.len);
                    credit += int'(a.len) / 4;
                end
            end
        end
    end

    // PCIe payload sink
    initial begin
        logic [127:0] e;
        bit have;
        bus.dma_write_data_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.dma_write_data_ready = 1'b0;
            end else begin
                bus.dma_write_data_ready = rnd_rdy();
                if (bus.dma_write_data_valid && bus.dma_write_data_ready) begin
                    have = exp_data.size() > 0;
                    e = '0;
                    if (have) e = exp_data.pop_front();
                    chk("data_present", have, 1);
                    chk("data", bus.dma_write_data, e);
                    chk("data_after_req", credit > 0, 1);
                    credit--;
                    data_beats++;
                end
            end
        end
    end

    // Interrupt acceptor
    initial begin
        bit e, have;
        bus.int_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.int_done = 1'b0;
            end else begin
                bus.int_done = bus.int_valid && rnd_rdy();
                if (bus.int_done) begin
                    have = exp_int.size() > 0;
                    e = 1'b0;
                    if (have) e = exp_int.pop_front();
                    chk("int_present", have, 1);
                    chk("int_axi_error", bus.axi_error, e);
                    ints_seen++;
                end
            end
        end
    end

    // Reference model: splits a job into chunks and queues every expected transfer.
    task automatic model_job(input logic [31:0] h, input logic [31:0] d, input logic [31:0] l,
                             input logic [2:0] code, input bit inj, input logic [31:0] ea,
                             output bit err);
        logic [31:0] hh, dd;
        int rem, c, mpsb, bnd;
        hh = h & ~32'hF;
        dd = d & ~32'hF;
        rem = int'(l >> 4);
        mpsb = (code >= 3'd2) ? 512 : (128 << code);
        err = 1'b0;
        while (rem > 0) begin
            bnd = (4096 - int'(hh % 4096)) / 16;
            c = rem;
            if (mpsb / 16 < c) c = mpsb / 16;
            if (bnd < c) c = bnd;
            exp_ar.push_back('{addr: dd, len: 10'(c - 1)});
            exp_req.push_back('{addr: hh, len: 10'(c * 4)});
            for (int i = 0; i < c; i++) begin
                exp_data.push_back(memf(dd + 32'(16 * i)));
                if (inj && (dd + 32'(16 * i)) == ea) err = 1'b1;
            end
            hh += 32'(16 * c);
            dd += 32'(16 * c);
            rem -= c;
        end
        exp_int.push_back(err);
        inject = inj;
        err_addr = ea;
    endtask

    task automatic start_job(input logic [31:0] h, input logic [31:0] d, input logic [31:0] l,
                             input logic [2:0] code);
        @(negedge clk);
        bus.dma_write_host_address   = h;
        bus.dma_write_device_address = d;
        bus.dma_write_length         = l;
        bus.pcie_dcommand            = {8'($urandom), code, 5'($urandom)};
        bus.dma_write_start          = 1'b1;
        @(negedge clk);
        bus.dma_write_start = 1'b0;
    endtask

    task automatic run_job(input logic [31:0] h, input logic [31:0] d, input logic [31:0] l,
                           input logic [2:0] code, input bit inj, input logic [31:0] ea,
                           input bit extra);
        bit err;
        int base, n;
        act_ar.delete();
        act_req.delete();
        data_beats = 0;
        model_job(h, d, l, code, inj, ea, err);
        base = ints_seen;
        start_job(h, d, l, code);
        chk("busy_after_start", bus.busy, 1);
        chk("axi_error_cleared", bus.axi_error, 0);
        if (l[31:4] == 28'd0) chk("zero_len_int_valid", bus.int_valid, 1);
        if (extra) begin
            repeat (8) @(negedge clk);
            start_job(32'hDEAD_0000, 32'hBEEF_0000, 32'h80, code);
            chk("busy_ignored_start", bus.busy, 1);
        end
        n = 0;
        while (ints_seen == base && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("job_done", ints_seen != base, 1);
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("axi_error_sticky", bus.axi_error, err);
        chk("ar_all_seen", exp_ar.size(), 0);
        chk("req_all_seen", exp_req.size(), 0);
        chk("data_all_seen", exp_data.size(), 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_arvalid"}, bus.arvalid, 0);
        chk({tag, "_rready"}, bus.rready, 0);
        chk({tag, "_req_valid"}, bus.dma_write_valid, 0);
        chk({tag, "_data_valid"}, bus.dma_write_data_valid, 0);
        chk({tag, "_int_valid"}, bus.int_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_axi_error"}, bus.axi_error, 0);
    endtask

    initial begin
        bit dummy;
        int n;
        logic [31:0] h;
        rst = 1'b1;
        bus.pcie_dcommand = '0;
        bus.dma_write_host_address = '0;
        bus.dma_write_device_address = '0;
        bus.dma_write_length = '0;
        bus.dma_write_start = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // 128 B MPS, 512 B job
        stall = 1'b0;
        run_job(32'h1000, 32'h0, 32'h200, 3'd0, 1'b0, 32'h0, 1'b0);
        chk("r027_nar", act_ar.size(), 4);
        chk("r027_nreq", act_req.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (act_ar.size() > i) chk("r027_arlen", act_ar[i].len, 10'd7);
            if (act_req.size() > i) begin
                chk("r027_req_addr", act_req[i].addr, 32'h1000 + 32'(i) * 32'h80);
                chk("r027_req_len", act_req[i].len, 10'd32);
            end
        end

        // 4 KB boundary split
        run_job(32'h1FC0, 32'h0, 32'h100, 3'd1, 1'b0, 32'h0, 1'b0);
        chk("r028_nreq", act_req.size(), 2);
        if (act_req.size() == 2) begin
            chk("r028_req0", act_req[0], {32'h1FC0, 10'd16});
            chk("r028_req1", act_req[1], {32'h2000, 10'd48});
        end

        // short job, 512 B MPS
        run_job(32'h4000, 32'h300, 32'h30, 3'd2, 1'b0, 32'h0, 1'b0);
        chk("r029_nar", act_ar.size(), 1);
        if (act_ar.size() > 0) chk("r029_arlen", act_ar[0].len, 10'd2);
        if (act_req.size() > 0) chk("r029_req_len", act_req[0].len, 10'd12);
        chk("r029_beats", data_beats, 3);

        // random 4 KB jobs under random stalls
        stall = 1'b1;
        for (int j = 0; j < 4; j++) begin
            h = $urandom;
            run_job(h & ~32'hF, $urandom, 32'h1000, 3'($urandom_range(0, 7)), 1'b0, 32'h0, 1'b0);
            chk("rand_beats", data_beats, 256);
        end

        // read error with an ignored mid-job start, then a clean job clears the flag
        run_job(32'h3F00, 32'h8000, 32'h400, 3'd1, 1'b1, 32'h8150, 1'b1);
        run_job(32'h6000, 32'h9000, 32'h40, 3'd0, 1'b0, 32'h0, 1'b0);

        // zero-length job
        run_job(32'h7000, 32'hA000, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0);
        chk("r032_no_ar", act_ar.size(), 0);
        chk("r032_no_req", act_req.size(), 0);

        // reset while streaming, then a clean job
        model_job(32'h2000, 32'h100, 32'h400, 3'd2, 1'b0, 32'h0, dummy);
        start_job(32'h2000, 32'h100, 32'h400, 3'd2);
        n = 0;
        while (!bus.dma_write_data_valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_stream", bus.dma_write_data_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midjob_rst");
        @(negedge clk);
        rst = 1'b0;
        exp_ar.delete();
        exp_req.delete();
        exp_data.delete();
        exp_int.delete();
        credit = 0;
        run_job(32'h5000, 32'hC000, 32'h200, 3'd2, 1'b0, 32'h0, 1'b0);
        chk("post_rst_beats", data_beats, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
